// File: rtl/positron_layer_serializer.sv
// positron_layer_serializer
// Collects the activated outputs of a layer of NB_LANES positrons and
// replays them as one sow/eow framed serial vector into the next layer.
//
// Optional build macro: POSITRON_SERIALIZER_PINGPONG_EN
//   Adds a second capture bank so the next vector can be collected while
//   the current one is emitted; vectors then stream back to back.
//
// state   | meaning
// COLLECT | waiting for every lane to deliver its eow word
// EMIT    | replaying the captured vector, one word per rts/rtr transfer
module positron_layer_serializer #(
    parameter int POSIT_WIDTH = 4,
    parameter int NB_LANES    = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NB_LANES-1:0]             rts_i,
    input  logic [NB_LANES-1:0]             eow_i,
    input  logic [NB_LANES*POSIT_WIDTH-1:0] posit_i,
    output logic [NB_LANES-1:0]             rtr_o,
    input  logic                            rtr_i,
    output logic                            rts_o,
    output logic                            sow_o,
    output logic                            eow_o,
    output logic [POSIT_WIDTH-1:0]          posit_o
);

    localparam int IDX_WIDTH = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NB_LANES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   idx;
    logic [NB_LANES-1:0]    cap;
    logic                   xfer;
    logic                   last_beat;

    // A lane only delivers a word at its end of window.
    assign cap       = rts_i & eow_i & rtr_o;
    assign xfer      = (state == EMIT) & rtr_i;
    assign last_beat = (idx == LAST_IDX);

`ifdef POSITRON_SERIALIZER_PINGPONG_EN
    logic [POSIT_WIDTH-1:0] buf_q [2][NB_LANES];
    logic [NB_LANES-1:0]    captured_q [2];
    logic                   wr_bank;
    logic                   rd_bank;
    logic                   pending;
    logic                   fill;

    assign rtr_o = ~captured_q[wr_bank];

    // While a full bank is queued behind the emitting one, wr_bank points at
    // the emitting bank (all flags set), so that case must not count as a fill.
    assign fill = ((captured_q[wr_bank] | cap) == {NB_LANES{1'b1}})
                & ~((state == EMIT) & (wr_bank == rd_bank));

    // Capture into the collect bank, hand full banks over to the emitter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            idx     <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            pending <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                captured_q[b] <= '0;
                for (int k = 0; k < NB_LANES; k++) begin
                    buf_q[b][k] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < NB_LANES; k++) begin
                if (cap[k]) begin
                    buf_q[wr_bank][k] <= posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
                end
            end
            captured_q[wr_bank] <= captured_q[wr_bank] | cap;
            if (fill) begin
                wr_bank <= ~wr_bank;
            end
            case (state)
                COLLECT: begin
                    if (fill) begin
                        state   <= EMIT;
                        rd_bank <= wr_bank;
                        idx     <= '0;
                    end
                end
                EMIT: begin
                    if (fill) begin
                        pending <= 1'b1;
                    end
                    if (xfer) begin
                        if (last_beat) begin
                            captured_q[rd_bank] <= '0;
                            idx                 <= '0;
                            pending             <= 1'b0;
                            if (pending | fill) begin
                                rd_bank <= ~rd_bank;
                            end else begin
                                state <= COLLECT;
                            end
                        end else begin
                            idx <= idx + IDX_WIDTH'(1);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign posit_o = (state == EMIT) ? buf_q[rd_bank][idx] : '0;
`else
    logic [POSIT_WIDTH-1:0] buf_q [NB_LANES];
    logic [NB_LANES-1:0]    captured_q;

    // Upstream is held off during EMIT and per lane once its word is in.
    assign rtr_o = {NB_LANES{state == COLLECT}} & ~captured_q;

    // Collect lane words, then step through them one transfer at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            idx        <= '0;
            captured_q <= '0;
            for (int k = 0; k < NB_LANES; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    for (int k = 0; k < NB_LANES; k++) begin
                        if (cap[k]) begin
                            buf_q[k] <= posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
                        end
                    end
                    captured_q <= captured_q | cap;
                    if ((captured_q | cap) == {NB_LANES{1'b1}}) begin
                        state <= EMIT;
                        idx   <= '0;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (last_beat) begin
                            state      <= COLLECT;
                            idx        <= '0;
                            captured_q <= '0;
                        end else begin
                            idx <= idx + IDX_WIDTH'(1);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign posit_o = (state == EMIT) ? buf_q[idx] : '0;
`endif

    assign rts_o = (state == EMIT);
    assign sow_o = (state == EMIT) & (idx == '0);
    assign eow_o = (state == EMIT) & last_beat;

endmodule

// File: tb/tb_positron_layer_serializer.sv
// Bench for positron_layer_serializer (single-bank build): a vector-level
// reference model checked every cycle, directed scenarios with literal
// expectations, then randomized traffic.
module tb_positron_layer_serializer;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   rts_i, eow_i, rtr_o;
    logic [N*W-1:0] posit_i;
    logic           rtr_i, rts_o, sow_o, eow_o;
    logic [W-1:0]   posit_o;

    logic           rts1, eow1, rtr1, rtr_o1, rts_o1, sow_o1, eow_o1;
    logic [W-1:0]   posit1, posit_o1;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] xfers[$];

    always #5 clk = ~clk;

    positron_layer_serializer #(.POSIT_WIDTH(W), .NB_LANES(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .eow_i(eow_i), .posit_i(posit_i),
        .rtr_o(rtr_o), .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o),
        .posit_o(posit_o)
    );

    positron_layer_serializer #(.POSIT_WIDTH(W), .NB_LANES(1)) u_one (
        .clk(clk), .rst_n(rst_n), .rts_i(rts1), .eow_i(eow1), .posit_i(posit1),
        .rtr_o(rtr_o1), .rtr_i(rtr1), .rts_o(rts_o1), .sow_o(sow_o1), .eow_o(eow_o1),
        .posit_o(posit_o1)
    );

    // Reference model: a set of captured lane words and a beat position in
    // the vector being replayed.
    bit           m_emit = 1'b0;
    int           m_beat = 0;
    bit [N-1:0]   m_cap  = '0;
    logic [W-1:0] m_val [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_emit = 1'b0;
            m_beat = 0;
            m_cap  = '0;
            for (int k = 0; k < N; k++) m_val[k] = '0;
        end else if (m_emit) begin
            if (rtr_i) begin
                if (m_beat == N - 1) begin
                    m_emit = 1'b0;
                    m_beat = 0;
                    m_cap  = '0;
                end else begin
                    m_beat++;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (rts_i[k] && eow_i[k] && !m_cap[k]) begin
                    m_cap[k] = 1'b1;
                    m_val[k] = posit_i[k*W +: W];
                end
            end
            if (&m_cap) begin
                m_emit = 1'b1;
                m_beat = 0;
            end
        end
    end

    // Every-cycle comparison against the model; also logs accepted words.
    always @(negedge clk) begin
        logic [10:0] exp_v;
        logic [10:0] got_v;
        exp_v = {m_emit, m_emit && (m_beat == 0), m_emit && (m_beat == N - 1),
                 m_emit ? m_val[m_beat] : 4'h0, m_emit ? 4'h0 : ~m_cap};
        got_v = {rts_o, sow_o, eow_o, posit_o, rtr_o};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got rts/sow/eow/posit/rtr=%b required=%b",
                     $time, got_v, exp_v);
        end
        if (rts_o && rtr_i) xfers.push_back(posit_o);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic check_log(input string name, input logic [15:0] exp);
        logic [15:0] got;
        got = '0;
        chk({name, "_count"}, 32'(xfers.size()), 32'd4);
        for (int i = 0; i < xfers.size() && i < 4; i++) got[i*W +: W] = xfers[i];
        chk(name, 32'(got), 32'(exp));
    endtask

    task automatic fill(input logic [15:0] vals);
        rts_i   = '1;
        eow_i   = '1;
        posit_i = vals;
        tick();
        rts_i   = '0;
        eow_i   = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        rts_i = '0; eow_i = '0; posit_i = '0; rtr_i = 1'b1;
        rts1 = 1'b0; eow1 = 1'b0; posit1 = '0; rtr1 = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'({rts_o, sow_o, eow_o, posit_o, rtr_o}), 32'({3'b000, 4'h0, 4'hF}));
        chk("reset_rtr_one", 32'({rts_o1, rtr_o1}), 32'b01);
        rst_n = 1'b1;
        tick();

        // all lanes in one cycle
        xfers.delete();
        fill(16'h4321);
        @(negedge clk);
        chk("t1_first_beat", 32'({rts_o, sow_o, eow_o, posit_o, rtr_o}), 32'({3'b110, 4'h1, 4'h0}));
        repeat (4) tick();
        @(negedge clk);
        chk("t1_after_rtr", 32'({rts_o, rtr_o}), 32'({1'b0, 4'hF}));
        check_log("t1_order", 16'h4321);

        // staggered capture, ignored rts without eow, ignored re-send
        xfers.delete();
        rts_i = 4'b0101; eow_i = 4'b0100; posit_i = 16'h0C07;
        tick();
        rts_i = 4'b0100; eow_i = 4'b0100; posit_i = 16'h0500;
        repeat (2) tick();
        rts_i = 4'b0011; eow_i = 4'b0011; posit_i = 16'h00BA;
        tick();
        rts_i = '0; eow_i = '0; posit_i = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("t2_waiting", 32'({rts_o, rtr_o}), 32'({1'b0, 4'b1000}));
        rts_i = 4'b1000; eow_i = 4'b1000; posit_i = 16'hD000;
        tick();
        rts_i = '0; eow_i = '0;
        @(negedge clk);
        chk("t2_first_beat", 32'({rts_o, sow_o, posit_o}), 32'({2'b11, 4'hA}));
        repeat (5) tick();
        check_log("t2_order", 16'hDCBA);

        // back-pressure while idx == 1
        xfers.delete();
        fill(16'h6789);
        tick();
        rtr_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("t3_hold", 32'({rts_o, sow_o, eow_o, posit_o}), 32'({3'b100, 4'h8}));
        end
        rtr_i = 1'b1;
        repeat (5) tick();
        check_log("t3_order", 16'h6789);

        // reset mid-EMIT
        xfers.delete();
        fill(16'h1234);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_async", 32'({rts_o, rtr_o}), 32'({1'b0, 4'hF}));
        tick();
        rst_n = 1'b1;
        tick();
        xfers.delete();
        fill(16'hF08A);
        repeat (5) tick();
        check_log("t5_after_reset", 16'hF08A);

        // single-lane instance
        rts1 = 1'b1; eow1 = 1'b0; posit1 = 4'h3;
        tick();
        @(negedge clk);
        chk("one_no_eow", 32'({rts_o1, rtr_o1}), 32'b01);
        eow1 = 1'b1; posit1 = 4'hB;
        tick();
        rts1 = 1'b0; eow1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("one_beat", 32'({rts_o1, sow_o1, eow_o1, posit_o1, rtr_o1}), 32'({3'b111, 4'hB, 1'b0}));
            tick();
        end
        rtr1 = 1'b1;
        tick();
        @(negedge clk);
        chk("one_done", 32'({rts_o1, rtr_o1}), 32'b01);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rts_i   = 4'($urandom);
            eow_i   = 4'($urandom);
            posit_i = 16'($urandom);
            rtr_i   = ($urandom_range(0, 3) != 0);
            tick();
        end
        rts_i = '0; eow_i = '0; rtr_i = 1'b1;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/positron_layer_serializer.md
Name: positron_layer_serializer

Overview:
- Sits directly downstream of a layer of NB_LANES parallel positron_4_0 instances.
- Captures each lane's activated posit_o when that lane signals rts_o/eow_o.
- Once every lane is captured, replays the vector as a serial stream (rts/rtr, sow/eow framed) into the next layer's positron posit_i/rts_i/sow_i/eow_i.

Parameters:
- POSIT_WIDTH, 4, width of one posit word.
- NB_LANES, 10, number of upstream positrons (output vector length); legal range 1 or more.
- IDX_WIDTH is a localparam: max(1, clog2(NB_LANES)). It is not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- rts_i  in  NB_LANES  per-lane ready-to-send from upstream positron.
- eow_i  in  NB_LANES  per-lane end-of-window from upstream positron.
- posit_i  in  NB_LANES*POSIT_WIDTH  lane k occupies bits [k*POSIT_WIDTH +: POSIT_WIDTH].
- rtr_o  out  NB_LANES  per-lane ready-to-receive back to upstream positron.
- rtr_i  in  1  downstream ready-to-receive.
- rts_o  out  1  serial word valid.
- sow_o  out  1  first word of vector; qualified by rts_o.
- eow_o  out  1  last word of vector; qualified by rts_o.
- posit_o  out  POSIT_WIDTH  serial posit word.

Interface: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Storage:
  - buf[NB_LANES] of POSIT_WIDTH bits.
  - captured[NB_LANES] flags.
  - state register in {COLLECT, EMIT}.
  - idx counter of IDX_WIDTH bits.
- Reset (async, rst_n=0): state=COLLECT, captured=0, idx=0, buf=0.
  - Outputs during reset: rts_o=0, sow_o=0, eow_o=0, posit_o=0, rtr_o=all ones.
- rtr_o[k] = (state==COLLECT) & ~captured[k]. It is combinational from registers only, with no path from rts_i or rtr_i.
- Lane capture:
  - Occurs on a clock edge when rts_i[k] & eow_i[k] & rtr_o[k].
  - Effect: buf[k]<=posit_i lane k, captured[k]<=1.
  - rts_i[k] without eow_i[k] is ignored; positron rts is only meaningful at eow.
  - Lanes capture independently and in any order; multiple lanes may capture in the same cycle.
  - A lane already captured is not overwritten, because its rtr_o is low.
- COLLECT -> EMIT:
  - Taken on the edge where (captured | newly captured) == all ones; idx<=0.
  - The last capture at edge t gives rts_o=1 in the cycle after t (1-cycle latency).
- EMIT:
  - rts_o=1, posit_o=buf[idx], sow_o=(idx==0), eow_o=(idx==NB_LANES-1).
  - A transfer occurs when rts_o & rtr_i.
  - rtr_i low stalls the beat: posit_o, sow_o and eow_o stay stable.
  - Transfer with idx<NB_LANES-1: idx<=idx+1.
  - Transfer with idx==NB_LANES-1: state<=COLLECT, idx<=0, captured<=0.
- Outside EMIT, rts_o/sow_o/eow_o=0 and posit_o=0.
- NB_LANES=1: the single beat carries sow_o=eow_o=1.
- Data is passed bit-exact, with no arithmetic on posits; NaR and zero patterns pass through unchanged.
- Reset asserted mid-EMIT or mid-COLLECT aborts the vector with no partial-vector recovery; the block restarts in COLLECT with all flags clear.
- Throughput without the optional feature: one vector per (collect time + NB_LANES beats); upstream is back-pressured throughout EMIT.

Optional Feature:
- Macro: POSITRON_SERIALIZER_PINGPONG_EN.
- When defined, two banks (A, B) are provided, each with its own buf and captured flags.
  - Writes go to the collect bank (wr_bank). Reads go to the emit bank (rd_bank).
  - rtr_o[k] = ~captured[wr_bank][k], independent of emit state.
  - When the collect bank fills and no bank is emitting: that bank becomes the emit bank, wr_bank toggles, rts_o rises next cycle.
  - When the collect bank fills while the other bank is still emitting: the full bank waits. rtr_o for that bank stays low because all flags are set. It starts emitting the cycle after the other bank's eow transfer, with zero bubble beats between vectors.
  - Emitted banks clear their flags on their eow transfer.
- When undefined, a single bank is used and behaviour is exactly as described above.

Test Plan:
- Fill all lanes in one cycle:
  - Stimulus: NB_LANES=4; lanes 0..3 present 4'h1,4'h2,4'h3,4'h4 with rts_i=eow_i=4'b1111 at edge t; rtr_i=1.
  - Required response: beats at t+1..t+4 give posit_o=1,2,3,4; sow_o only on the first beat, eow_o only on the fourth; rtr_o=0 for t+1..t+4, back to 4'b1111 after.
- Staggered capture:
  - Stimulus: lanes captured at edges 0,3,3,7 in the order 2,0,1,3.
  - Required response: rts_o first high the cycle after edge 7; data order is lane 0..3 regardless of capture order.
- Back-pressure:
  - Stimulus: rtr_i=0 for 3 cycles while idx=1.
  - Required response: posit_o=buf[1], sow_o=0, eow_o=0 held stable; idx advances only after rtr_i returns to 1; exactly 4 transfers total.
- Ignored inputs:
  - Stimulus: rts_i[0]=1 with eow_i[0]=0; also a lane re-asserting rts_i&eow_i after capture with a different value.
  - Required response: no capture in either case; the original value is emitted.
- Reset mid-EMIT:
  - Stimulus: rst_n pulsed low at idx=2.
  - Required response: rts_o=0 immediately (async); after release rtr_o=all ones; a new vector emits correctly from idx 0.
- NB_LANES=1 and ping-pong:
  - Stimulus: with NB_LANES=1, one capture; with PINGPONG_EN and NB_LANES=4, two back-to-back vectors.
  - Required response: NB_LANES=1 gives a single beat with sow_o=eow_o=1. Ping-pong gives 8 consecutive transfers with rtr_i=1 and no idle cycle; the second vector collects while the first emits.
